// File: rtl/wb_ic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ic_pkg
//  Purpose  : Shared definitions for the Wishbone data/instruction
//             interconnects: FSM state encoding, default SoC address map,
//             decoder miss value and a width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wb_ic_pkg;

    // Interconnect FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DERR = 2'd2;

    // Default SoC address map (slave index order: MEM=0, MTIME=1, UART=2, LOADER=3)
    localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK    = 32'hFFFF_8000;
    localparam logic [31:0] MTIME_BASE  = 32'h0000_8000;
    localparam logic [31:0] MTIME_MASK  = 32'hFFFF_FFF0;
    localparam logic [31:0] UART_BASE   = 32'h0000_8010;
    localparam logic [31:0] UART_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] LOADER_BASE = 32'h0000_8014;
    localparam logic [31:0] LOADER_MASK = 32'hFFFF_FFFC;

    // Index reported by the decoder when no slave matches
    localparam int unsigned DECODE_MISS = 0;

    // $clog2 clamped to at least one bit so degenerate sizes still get a port
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage : wb_ic_pkg
`default_nettype wire

// File: rtl/wb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : wb_addr_decoder
//  Purpose  : Combinational base/mask address decoder with lowest-index
//             priority when several windows overlap.
//  Ports    : adr_i  - address to decode
//             hit_o  - one-hot selected slave (all zero on miss)
//             idx_o  - binary index of selected slave (DECODE_MISS on miss)
//             miss_o - no slave matched
//  Revision : 1.0 - initial release
// ============================================================================
module wb_addr_decoder
    import wb_ic_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       IDX_W      = 2,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = '0
) (
    input  logic [31:0]           adr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  miss_o
);

    logic [NUM_SLAVES-1:0] w_match;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_match
        assign w_match[k] = (adr_i & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32];
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit_o  = '0;
        idx_o  = IDX_W'(DECODE_MISS);
        miss_o = 1'b1;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                hit_o    = '0;
                hit_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
                miss_o   = 1'b0;
            end
        end
    end

endmodule : wb_addr_decoder
`default_nettype wire

// File: rtl/wb_data_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : wb_data_interconnect
//  Purpose  : Single-master, N-slave pipelined Wishbone interconnect for the
//             core data port. One outstanding transfer; unmapped addresses
//             and response timeouts return a bus error.
//  Ports    : wb_clk_i/wb_rst_i        - clock, async active-high reset
//             m_wb_*                   - master-side pipelined Wishbone
//             s_wb_cyc_o/s_wb_stb_o    - per-slave cycle/strobe
//             s_wb_we/adr/dat/sel_o    - broadcast request fields
//             s_wb_stall/ack/err_i     - per-slave handshakes
//             s_wb_dat_i               - flattened per-slave read data
//             timeout_o                - pulse when a timeout error is issued
//  Revision : 1.0 - initial release
// ============================================================================
module wb_data_interconnect
    import wb_ic_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {LOADER_BASE, UART_BASE, MTIME_BASE, MEM_BASE},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {LOADER_MASK, UART_MASK, MTIME_MASK, MEM_MASK},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     m_wb_cyc_i,
    input  logic                     m_wb_stb_i,
    input  logic                     m_wb_we_i,
    input  logic [31:0]              m_wb_adr_i,
    input  logic [31:0]              m_wb_dat_i,
    input  logic [3:0]               m_wb_sel_i,
    output logic                     m_wb_stall_o,
    output logic                     m_wb_ack_o,
    output logic                     m_wb_err_o,
    output logic [31:0]              m_wb_dat_o,
    output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
    output logic                     s_wb_we_o,
    output logic [31:0]              s_wb_adr_o,
    output logic [31:0]              s_wb_dat_o,
    output logic [3:0]               s_wb_sel_o,
    input  logic [NUM_SLAVES-1:0]    s_wb_stall_i,
    input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_wb_err_i,
    input  logic [32*NUM_SLAVES-1:0] s_wb_dat_i,
    output logic                     timeout_o
);

    localparam int IDX_W = clog2_min1(NUM_SLAVES);
    localparam int TMR_W = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMER_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [NUM_SLAVES-1:0] w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_miss;
    logic                  w_req;
    logic [31:0]           w_slave_dat [NUM_SLAVES];

    // Broadcast request fields go straight through; only cyc/stb are gated.
    assign s_wb_we_o  = m_wb_we_i;
    assign s_wb_adr_o = m_wb_adr_i;
    assign s_wb_dat_o = m_wb_dat_i;
    assign s_wb_sel_o = m_wb_sel_i;

    assign w_req = m_wb_cyc_i & m_wb_stb_i;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_unpack_dat
        assign w_slave_dat[k] = s_wb_dat_i[32*k +: 32];
    end

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .adr_i  (m_wb_adr_i),
        .hit_o  (w_hit),
        .idx_o  (w_idx),
        .miss_o (w_miss)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        timer_d      = timer_q;
        s_wb_cyc_o   = '0;
        s_wb_stb_o   = '0;
        m_wb_stall_o = 1'b1;
        m_wb_ack_o   = 1'b0;
        m_wb_err_o   = 1'b0;
        m_wb_dat_o   = '0;
        timeout_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                m_wb_stall_o = 1'b0;
                if (w_req) begin
                    if (w_miss) begin
                        state_d = ST_DERR;
                    end else begin
                        s_wb_cyc_o = w_hit;
                        s_wb_stb_o = w_hit;
                        if (s_wb_stall_i[w_idx]) begin
                            m_wb_stall_o = 1'b1;
                        end else begin
                            sel_d   = w_idx;
                            timer_d = '0;
                            state_d = ST_WAIT;
                        end
                    end
                end
            end

            ST_DERR: begin
                m_wb_err_o = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_WAIT: begin
                // Only the owning slave keeps cyc, so a late ack after an
                // abort cannot be mistaken for a response.
                s_wb_cyc_o[sel_q] = m_wb_cyc_i;
                if (!m_wb_cyc_i) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (s_wb_ack_i[sel_q] || s_wb_err_i[sel_q]) begin
                    m_wb_ack_o = s_wb_ack_i[sel_q];
                    m_wb_err_o = s_wb_err_i[sel_q];
                    m_wb_dat_o = s_wb_ack_i[sel_q] ? w_slave_dat[sel_q] : 32'h0;
                    state_d    = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                    m_wb_err_o = 1'b1;
                    timeout_o  = 1'b1;
                    state_d    = ST_IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset forces a quiet bus immediately, independent of the clock.
        if (wb_rst_i) begin
            s_wb_cyc_o   = '0;
            s_wb_stb_o   = '0;
            m_wb_stall_o = 1'b1;
            m_wb_ack_o   = 1'b0;
            m_wb_err_o   = 1'b0;
            m_wb_dat_o   = '0;
            timeout_o    = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
        end
    end

endmodule : wb_data_interconnect
`default_nettype wire

// File: tb/tb_wb_data_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_data_interconnect
//  Purpose  : Directed self-checking bench for wb_data_interconnect with the
//             default address map and an 8-cycle response timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_data_interconnect;

    localparam int NS = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0]   m_adr = '0, m_wdat = '0;
    logic [3:0]    m_sel = '0;
    logic          m_stall, m_ack, m_err;
    logic [31:0]   m_rdat;
    logic [NS-1:0] s_cyc, s_stb;
    logic          s_we;
    logic [31:0]   s_adr, s_wdat;
    logic [3:0]    s_sel;
    logic [NS-1:0] s_stall = '0, s_ack = '0, s_err = '0;
    logic [31:0]   sdat [NS];
    logic          tmo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_data_interconnect #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .m_wb_cyc_i   (m_cyc),
        .m_wb_stb_i   (m_stb),
        .m_wb_we_i    (m_we),
        .m_wb_adr_i   (m_adr),
        .m_wb_dat_i   (m_wdat),
        .m_wb_sel_i   (m_sel),
        .m_wb_stall_o (m_stall),
        .m_wb_ack_o   (m_ack),
        .m_wb_err_o   (m_err),
        .m_wb_dat_o   (m_rdat),
        .s_wb_cyc_o   (s_cyc),
        .s_wb_stb_o   (s_stb),
        .s_wb_we_o    (s_we),
        .s_wb_adr_o   (s_adr),
        .s_wb_dat_o   (s_wdat),
        .s_wb_sel_o   (s_sel),
        .s_wb_stall_i (s_stall),
        .s_wb_ack_i   (s_ack),
        .s_wb_err_i   (s_err),
        .s_wb_dat_i   ({sdat[3], sdat[2], sdat[1], sdat[0]}),
        .timeout_o    (tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge; callers drive, then settle.
    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic request(input logic [31:0] adr, input logic we);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we;
    endtask

    initial begin
        sdat[0] = 32'h0; sdat[1] = 32'h1111_1111; sdat[2] = 32'h2222_2222; sdat[3] = 32'h3333_3333;

        // ---------------- reset values ----------------
        #2;
        request(32'h0000_0040, 1'b0);
        #1;
        check("rst_stall", {31'd0, m_stall}, 32'd1);
        check("rst_cyc",   {28'd0, s_cyc},   32'd0);
        check("rst_stb",   {28'd0, s_stb},   32'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        next_cycle();
        wb_rst_i = 1'b0;
        #1;
        check("idle_stall", {31'd0, m_stall}, 32'd0);
        check("idle_ack",   {31'd0, m_ack},   32'd0);

        // ---------------- read slave0, ack next cycle ----------------
        next_cycle();
        request(32'h0000_0040, 1'b0);
        #1;
        check("rd0_stb",   {28'd0, s_stb}, 32'b0001);
        check("rd0_stall", {31'd0, m_stall}, 32'd0);
        next_cycle();
        m_stb = 1'b0; s_ack[0] = 1'b1; sdat[0] = 32'hDEAD_BEEF;
        #1;
        check("rd0_stb_wait", {28'd0, s_stb},   32'd0);
        check("rd0_ack",      {31'd0, m_ack},   32'd1);
        check("rd0_dat",      m_rdat,           32'hDEAD_BEEF);
        check("rd0_stall_w",  {31'd0, m_stall}, 32'd1);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0;
        #1;
        check("rd0_ack_off", {31'd0, m_ack}, 32'd0);
        check("rd0_dat_off", m_rdat,         32'd0);

        // ---------------- write slave2 with 3 stall cycles ----------------
        next_cycle();
        request(32'h0000_8010, 1'b1);
        m_sel = 4'b0001; m_wdat = 32'hCAFE_0123; s_stall[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wr2_stall", {31'd0, m_stall}, 32'd1);
            check("wr2_stb",   {28'd0, s_stb},   32'b0100);
            check("wr2_bdat",  s_wdat,           32'hCAFE_0123);
            check("wr2_bsel",  {28'd0, s_sel},   32'b0001);
            next_cycle();
        end
        s_stall[2] = 1'b0;
        #1;
        check("wr2_accept", {31'd0, m_stall}, 32'd0);
        check("wr2_stb4",   {28'd0, s_stb},   32'b0100);
        check("wr2_we",     {31'd0, s_we},    32'd1);
        next_cycle();
        m_stb = 1'b0; s_ack[2] = 1'b1;
        #1;
        check("wr2_ack", {31'd0, m_ack}, 32'd1);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0;
        #1;
        check("wr2_ack_once", {31'd0, m_ack}, 32'd0);

        // ---------------- unmapped address ----------------
        next_cycle();
        request(32'h0000_9000, 1'b0);
        m_sel = 4'b1111;
        #1;
        check("um_stb",   {28'd0, s_stb},   32'd0);
        check("um_stall", {31'd0, m_stall}, 32'd0);
        check("um_err0",  {31'd0, m_err},   32'd0);
        next_cycle();
        m_stb = 1'b0;
        #1;
        check("um_err",   {31'd0, m_err},   32'd1);
        check("um_dstal", {31'd0, m_stall}, 32'd1);
        check("um_dat",   m_rdat,           32'd0);
        check("um_stb2",  {28'd0, s_stb},   32'd0);
        next_cycle();
        m_cyc = 1'b0;
        #1;
        check("um_err_off", {31'd0, m_err}, 32'd0);

        // ---------------- timeout on slave3 ----------------
        next_cycle();
        request(32'h0000_8014, 1'b0);
        #1;
        check("to_stb", {28'd0, s_stb}, 32'b1000);
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            m_stb = 1'b0;
            #1;
            check("to_cyc", {28'd0, s_cyc}, 32'b1000);
            check("to_err", {31'd0, m_err}, (i == 8) ? 32'd1 : 32'd0);
            check("to_pls", {31'd0, tmo},   (i == 8) ? 32'd1 : 32'd0);
        end
        next_cycle();
        request(32'h0000_0040, 1'b0);
        #1;
        check("to_next_stall", {31'd0, m_stall}, 32'd0);
        check("to_next_stb",   {28'd0, s_stb},   32'b0001);
        check("to_tmo_off",    {31'd0, tmo},     32'd0);
        next_cycle();
        m_stb = 1'b0; s_ack[0] = 1'b1; sdat[0] = 32'h0BAD_F00D;
        #1;
        check("to_next_dat", m_rdat, 32'h0BAD_F00D);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0;

        // ---------------- ack only from owning slave ----------------
        next_cycle();
        request(32'h0000_8000, 1'b0);
        #1;
        check("own_stb", {28'd0, s_stb}, 32'b0010);
        next_cycle();
        m_stb = 1'b0; s_ack[2] = 1'b1;
        #1;
        check("own_foreign", {31'd0, m_ack}, 32'd0);
        next_cycle();
        s_ack[1] = 1'b1;
        #1;
        check("own_ack", {31'd0, m_ack}, 32'd1);
        check("own_dat", m_rdat,         32'h1111_1111);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0;

        // ---------------- ack and err together ----------------
        next_cycle();
        request(32'h0000_0040, 1'b0);
        next_cycle();
        m_stb = 1'b0; s_ack[0] = 1'b1; s_err[0] = 1'b1;
        #1;
        check("ae_ack", {31'd0, m_ack}, 32'd1);
        check("ae_err", {31'd0, m_err}, 32'd1);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0; s_err = '0;

        // ---------------- abort by dropping cyc ----------------
        next_cycle();
        request(32'h0000_0040, 1'b0);
        next_cycle();
        m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        check("ab_cyc", {28'd0, s_cyc}, 32'd0);
        check("ab_ack", {31'd0, m_ack}, 32'd0);
        next_cycle();
        s_ack[0] = 1'b1;
        #1;
        check("ab_stray", {31'd0, m_ack}, 32'd0);
        next_cycle();
        s_ack = '0;

        // ---------------- async reset during WAIT ----------------
        next_cycle();
        request(32'h0000_0040, 1'b0);
        next_cycle();
        m_stb = 1'b0;
        #1;
        check("ar_wait_cyc", {28'd0, s_cyc}, 32'b0001);
        wb_rst_i = 1'b1; s_ack[0] = 1'b1;
        #1;
        check("ar_cyc",   {28'd0, s_cyc},   32'd0);
        check("ar_stall", {31'd0, m_stall}, 32'd1);
        check("ar_ack",   {31'd0, m_ack},   32'd0);
        check("ar_dat",   m_rdat,           32'd0);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0; wb_rst_i = 1'b0;
        next_cycle();
        request(32'h0000_0040, 1'b0);
        #1;
        check("ar_new_stb", {28'd0, s_stb}, 32'b0001);
        next_cycle();
        m_stb = 1'b0; s_ack[0] = 1'b1; sdat[0] = 32'h1234_5678;
        #1;
        check("ar_new_ack", {31'd0, m_ack}, 32'd1);
        check("ar_new_dat", m_rdat,         32'h1234_5678);
        next_cycle();
        m_cyc = 1'b0; s_ack = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_data_interconnect
`default_nettype wire
